// File: rtl/load_return_unit_if.sv
// load_return_unit_if
//   Groups the pipeline-side request/response signals and the data-bus read
//   signals of the load return unit.
//   slave  : used by load_return_unit (takes requests, issues bus reads).
//   master : used by whatever drives the unit (pipeline plus bus model).
// Signals:
//   flush        pipeline -> unit  abort the in-flight load
//   req_valid    pipeline -> unit  load request present
//   req_addr     pipeline -> unit  byte address
//   req_op       pipeline -> unit  0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu
//   req_ready    unit -> pipeline  unit can accept a request
//   stall        unit -> pipeline  pipeline hold
//   bus_rd_en    unit -> bus       one-cycle read strobe
//   bus_addr     unit -> bus       word-aligned read address
//   bus_rdata    bus -> unit       read data
//   bus_rvalid   bus -> unit       read data valid
//   resp_valid   unit -> pipeline  one-cycle result pulse
//   resp_data    unit -> pipeline  extended load result
//   resp_exc     unit -> pipeline  exception flag
//   resp_exccode unit -> pipeline  4 AdEL, 7 bus timeout
interface load_return_unit_if;
  logic        flush;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_op;
  logic        req_ready;
  logic        stall;
  logic        bus_rd_en;
  logic [31:0] bus_addr;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_exc;
  logic [4:0]  resp_exccode;

  modport slave (
    input  flush, req_valid, req_addr, req_op, bus_rdata, bus_rvalid,
    output req_ready, stall, bus_rd_en, bus_addr,
           resp_valid, resp_data, resp_exc, resp_exccode
  );

  modport master (
    output flush, req_valid, req_addr, req_op, bus_rdata, bus_rvalid,
    input  req_ready, stall, bus_rd_en, bus_addr,
           resp_valid, resp_data, resp_exc, resp_exccode
  );
endinterface

// File: rtl/load_return_unit.sv
// load_return_unit
//   MEM-stage load path: accepts one load at a time, checks address/width
//   against the memory map, issues a word-aligned bus read, waits for the
//   read data and returns the sign/zero-extended result (or an AdEL
//   exception) with a one-cycle response pulse. stall holds the pipeline
//   while a load is outstanding.
// Ports:
//   clk      clock, rising edge
//   reset_n  asynchronous active-low reset
//   lru      load_return_unit_if.slave (request, bus and response signals)
// Parameters:
//   TIMEOUT_CYCLES  WAIT cycles without read data before a bus timeout
// Build option:
//   LOAD_TIMEOUT_EN  when defined, a load whose data does not arrive within
//                    TIMEOUT_CYCLES WAIT cycles returns exception code 7 and
//                    the late data is dropped. Undefined: WAIT never times out.
//
// state | meaning
// IDLE  | ready for a request (unless a dropped read is still outstanding)
// ISSUE | bus read strobe for the latched, word-aligned address
// WAIT  | waiting for bus_rvalid
// RESP  | one-cycle response with data or exception
module load_return_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               reset_n,
  load_return_unit_if.slave lru
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LB  = 3'd4;
  localparam logic [2:0] OP_LBU = 3'd5;

  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_TIMEOUT = 5'd7;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("load_return_unit: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [2:0]  op_q, op_nxt;
  logic        drop_q, drop_nxt;
  logic [31:0] data_q, data_nxt;
  logic        exc_q, exc_nxt;
  logic [4:0]  code_q, code_nxt;

  logic        req_op_ok;
  logic        req_addr_bad;
  logic        timeout_hit;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  function automatic logic addr_bad(input logic [31:0] a, input logic [2:0] op);
    logic in_dm;
    logic in_tmr;
    logic in_int;
    logic misaligned;
    in_dm      = (a <= 32'h0000_2FFF);
    in_tmr     = ((a >= 32'h0000_7F00) && (a <= 32'h0000_7F0B)) ||
                 ((a >= 32'h0000_7F10) && (a <= 32'h0000_7F1B));
    in_int     = (a >= 32'h0000_7F20) && (a <= 32'h0000_7F23);
    misaligned = ((op == OP_LW) && (a[1:0] != 2'b00)) ||
                 (((op == OP_LH) || (op == OP_LHU)) && a[0]);
    // timer registers only support full-word access
    return !(in_dm || in_tmr || in_int) || misaligned || (in_tmr && (op != OP_LW));
  endfunction

  assign req_op_ok    = (lru.req_op >= OP_LW) && (lru.req_op <= OP_LBU);
  assign req_addr_bad = addr_bad(lru.req_addr, lru.req_op);

`ifdef LOAD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] wait_cnt_q;

  // loaded while issuing, counts down through WAIT, zero elsewhere
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      wait_cnt_q <= CW'(TIMEOUT_CYCLES - 1);
    end else if ((state_q == WAIT) && (wait_cnt_q != '0)) begin
      wait_cnt_q <= wait_cnt_q - 1'b1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  assign timeout_hit = (state_q == WAIT) && (wait_cnt_q == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    byte_sel = lru.bus_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    byte_sel = lru.bus_rdata[7:0];
      2'd1:    byte_sel = lru.bus_rdata[15:8];
      2'd2:    byte_sel = lru.bus_rdata[23:16];
      default: byte_sel = lru.bus_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? lru.bus_rdata[31:16] : lru.bus_rdata[15:0];
    case (op_q)
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0000, half_sel};
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h000000, byte_sel};
      default: load_data = lru.bus_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state_q;
    addr_nxt  = addr_q;
    op_nxt    = op_q;
    drop_nxt  = drop_q;
    data_nxt  = data_q;
    exc_nxt   = exc_q;
    code_nxt  = code_q;

    // a read abandoned by flush or timeout completes outside WAIT
    if ((state_q != WAIT) && lru.bus_rvalid) begin
      drop_nxt = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!lru.flush && !drop_q && lru.req_valid && req_op_ok) begin
          addr_nxt = lru.req_addr;
          op_nxt   = lru.req_op;
          data_nxt = 32'h0;
          if (req_addr_bad) begin
            exc_nxt   = 1'b1;
            code_nxt  = EXC_ADEL;
            state_nxt = RESP;
          end else begin
            exc_nxt   = 1'b0;
            code_nxt  = 5'd0;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_nxt = lru.flush ? IDLE : WAIT;
      end
      WAIT: begin
        if (lru.flush) begin
          // data arriving with the flush is simply discarded
          drop_nxt  = !lru.bus_rvalid;
          state_nxt = IDLE;
        end else if (lru.bus_rvalid) begin
          data_nxt  = load_data;
          exc_nxt   = 1'b0;
          code_nxt  = 5'd0;
          state_nxt = RESP;
        end else if (timeout_hit) begin
          data_nxt  = 32'h0;
          exc_nxt   = 1'b1;
          code_nxt  = EXC_TIMEOUT;
          drop_nxt  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      op_q    <= 3'd0;
      drop_q  <= 1'b0;
      data_q  <= 32'h0;
      exc_q   <= 1'b0;
      code_q  <= 5'd0;
    end else begin
      state_q <= state_nxt;
      addr_q  <= addr_nxt;
      op_q    <= op_nxt;
      drop_q  <= drop_nxt;
      data_q  <= data_nxt;
      exc_q   <= exc_nxt;
      code_q  <= code_nxt;
    end
  end

  assign lru.req_ready    = (state_q == IDLE) && !drop_q;
  assign lru.stall        = ((state_q == IDLE) && lru.req_valid && req_op_ok) ||
                            (state_q == ISSUE) || (state_q == WAIT);
  assign lru.bus_rd_en    = (state_q == ISSUE);
  assign lru.bus_addr     = {addr_q[31:2], 2'b00};
  assign lru.resp_valid   = (state_q == RESP) && !lru.flush;
  assign lru.resp_data    = data_q;
  assign lru.resp_exc     = exc_q;
  assign lru.resp_exccode = code_q;

endmodule

// File: tb/tb_load_return_unit.sv
module tb_load_return_unit;
`ifdef LOAD_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  load_return_unit_if lru_bus();

  load_return_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .lru(lru_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // per-cycle expectations, written by the stimulus, compared by the monitor
  logic        chk_en;
  logic        e_stall, e_ready, e_rd, e_rv;
  logic [31:0] e_addr, e_data;
  logic        e_exc;
  logic [4:0]  e_code;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // compare process: every cycle after reset release
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("stall", 32'(lru_bus.stall), 32'(e_stall));
        chk("req_ready", 32'(lru_bus.req_ready), 32'(e_ready));
        chk("bus_rd_en", 32'(lru_bus.bus_rd_en), 32'(e_rd));
        chk("resp_valid", 32'(lru_bus.resp_valid), 32'(e_rv));
        if (e_rd) chk("bus_addr", lru_bus.bus_addr, e_addr);
        if (e_rv) begin
          chk("resp_data", lru_bus.resp_data, e_data);
          chk("resp_exc", 32'(lru_bus.resp_exc), 32'(e_exc));
          chk("resp_exccode", 32'(lru_bus.resp_exccode), 32'(e_code));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  function automatic bit model_bad(input logic [2:0] op, input logic [31:0] a);
    bit          mapped;
    bit          timer;
    int unsigned size;
    mapped = (a < 32'h3000) || (a >= 32'h7F20 && a < 32'h7F24);
    timer  = (a >= 32'h7F00 && a < 32'h7F0C) || (a >= 32'h7F10 && a < 32'h7F1C);
    size   = (op == 3'd1) ? 4 : ((op == 3'd2 || op == 3'd3) ? 2 : 1);
    if (!(mapped || timer)) return 1'b1;
    if ((a % size) != 0) return 1'b1;
    if (timer && size != 4) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_ext(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] w);
    logic [31:0] v;
    int          sh;
    v = w;
    if (op == 3'd2 || op == 3'd3) begin
      sh = a[1] ? 16 : 0;
      v  = (w >> sh) & 32'h0000_FFFF;
      if (op == 3'd2 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else if (op == 3'd4 || op == 3'd5) begin
      sh = 8 * int'(a[1:0]);
      v  = (w >> sh) & 32'h0000_00FF;
      if (op == 3'd4 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1:    return 32'($urandom_range(0, 32'h2FFF));
      2:       return 32'h7F00 + 32'($urandom_range(0, 47));
      3:       return 32'h2FF0 + 32'($urandom_range(0, 31));
      4:       return 32'($urandom);
      default: return 32'h7EF0 + 32'($urandom_range(0, 63));
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_exp(input logic s, input logic r, input logic rd, input logic rv);
    e_stall = s;
    e_ready = r;
    e_rd    = rd;
    e_rv    = rv;
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lru_bus.flush      = 1'b0;
    lru_bus.req_valid  = 1'b0;
    lru_bus.req_op     = 3'd0;
    lru_bus.bus_rvalid = 1'b0;
  endtask

  // One load from an idle, ready unit. lat = empty WAIT cycles before rvalid.
  task automatic run_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] word,
                          input int lat, input logic [31:0] x_data, input logic x_exc,
                          input logic [4:0] x_code, input logic junk);
    lru_bus.req_valid = 1'b1;
    lru_bus.req_op    = op;
    lru_bus.req_addr  = addr;
    set_exp(1, 1, 0, 0);
    step();
    idle_inputs();
    lru_bus.req_addr = 32'($urandom);
    e_data = x_data;
    e_exc  = x_exc;
    e_code = x_code;
    if (!x_exc) begin
      e_addr = {addr[31:2], 2'b00};
      lru_bus.bus_rvalid = junk;
      set_exp(1, 0, 1, 0);
      step();
      lru_bus.bus_rvalid = 1'b0;
      for (int i = 0; i < lat; i++) begin
        set_exp(1, 0, 0, 0);
        step();
      end
      lru_bus.bus_rvalid = 1'b1;
      lru_bus.bus_rdata  = word;
      set_exp(1, 0, 0, 0);
      step();
      lru_bus.bus_rvalid = 1'b0;
      lru_bus.bus_rdata  = 32'($urandom);
    end
    set_exp(0, 0, 0, 1);
    step();
    set_exp(0, 1, 0, 0);
  endtask

  task automatic accept_and_issue(input logic [2:0] op, input logic [31:0] addr);
    lru_bus.req_valid = 1'b1;
    lru_bus.req_op    = op;
    lru_bus.req_addr  = addr;
    set_exp(1, 1, 0, 0);
    step();
    idle_inputs();
    e_addr = {addr[31:2], 2'b00};
    set_exp(1, 0, 1, 0);
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] w;
    logic        bad;

    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    set_exp(0, 1, 0, 0);
    e_addr = 0; e_data = 0; e_exc = 0; e_code = 0;
    idle_inputs();
    lru_bus.req_addr  = 32'h0;
    lru_bus.bus_rdata = 32'h0;
    reset_n = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(lru_bus.req_ready), 32'd1);
    chk("rst_stall", 32'(lru_bus.stall), 32'd0);
    chk("rst_bus_rd_en", 32'(lru_bus.bus_rd_en), 32'd0);
    chk("rst_bus_addr", lru_bus.bus_addr, 32'h0);
    chk("rst_resp_valid", 32'(lru_bus.resp_valid), 32'd0);
    chk("rst_resp_data", lru_bus.resp_data, 32'h0);
    chk("rst_resp_exc", 32'(lru_bus.resp_exc), 32'd0);
    chk("rst_resp_exccode", 32'(lru_bus.resp_exccode), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;
    step();

    // hand-computed results
    run_load(3'd4, 32'h0003, 32'h80FF1234, 0, 32'hFFFFFF80, 1'b0, 5'd0, 1'b0);
    run_load(3'd3, 32'h0002, 32'h80FF1234, 0, 32'h000080FF, 1'b0, 5'd0, 1'b0);
    run_load(3'd2, 32'h0002, 32'h80FF1234, 0, 32'hFFFF80FF, 1'b0, 5'd0, 1'b0);
    run_load(3'd1, 32'h7F08, 32'h00000005, 0, 32'h00000005, 1'b0, 5'd0, 1'b0);
    run_load(3'd1, 32'h0002, 32'h0, 0, 32'h0, 1'b1, 5'd4, 1'b0);
    run_load(3'd2, 32'h0001, 32'h0, 0, 32'h0, 1'b1, 5'd4, 1'b0);
    run_load(3'd4, 32'h7F04, 32'h0, 0, 32'h0, 1'b1, 5'd4, 1'b0);
    run_load(3'd1, 32'h3000, 32'h0, 0, 32'h0, 1'b1, 5'd4, 1'b0);
    run_load(3'd5, 32'h7F0C, 32'h0, 0, 32'h0, 1'b1, 5'd4, 1'b0);
    run_load(3'd1, 32'h2FFC, 32'hCAFEF00D, 2, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0);
    run_load(3'd1, 32'h0100, 32'hDEADBEEF, 5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
    run_load(3'd5, 32'h0001, 32'h0000A500, 1, 32'h000000A5, 1'b0, 5'd0, 1'b1);

    // flush in WAIT: stale read swallowed, next request held off until it lands
    accept_and_issue(3'd1, 32'h0040);
    lru_bus.flush = 1'b1;
    set_exp(1, 0, 0, 0);
    step();
    lru_bus.flush     = 1'b0;
    lru_bus.req_valid = 1'b1;
    lru_bus.req_op    = 3'd5;
    lru_bus.req_addr  = 32'h0000;
    set_exp(1, 0, 0, 0);
    step();
    step();
    lru_bus.bus_rvalid = 1'b1;
    lru_bus.bus_rdata  = 32'hAAAAAA55;
    step();
    lru_bus.bus_rvalid = 1'b0;
    run_load(3'd5, 32'h0000, 32'h123456F3, 0, 32'h000000F3, 1'b0, 5'd0, 1'b0);

    // flush and rvalid together in WAIT: no drop left behind
    accept_and_issue(3'd2, 32'h0010);
    lru_bus.flush      = 1'b1;
    lru_bus.bus_rvalid = 1'b1;
    set_exp(1, 0, 0, 0);
    step();
    idle_inputs();
    set_exp(0, 1, 0, 0);
    step();

    // flush in ISSUE, then a stray rvalid in IDLE is ignored
    lru_bus.req_valid = 1'b1;
    lru_bus.req_op    = 3'd1;
    lru_bus.req_addr  = 32'h0020;
    set_exp(1, 1, 0, 0);
    step();
    idle_inputs();
    lru_bus.flush = 1'b1;
    e_addr = 32'h0020;
    set_exp(1, 0, 1, 0);
    step();
    idle_inputs();
    lru_bus.bus_rvalid = 1'b1;
    set_exp(0, 1, 0, 0);
    step();
    idle_inputs();
    step();

    // flush during RESP suppresses the pulse
    lru_bus.req_valid = 1'b1;
    lru_bus.req_op    = 3'd1;
    lru_bus.req_addr  = 32'h0006;
    set_exp(1, 1, 0, 0);
    step();
    idle_inputs();
    lru_bus.flush = 1'b1;
    set_exp(0, 0, 0, 0);
    step();
    idle_inputs();
    set_exp(0, 1, 0, 0);
    step();

    // flush in IDLE blocks acceptance
    lru_bus.req_valid = 1'b1;
    lru_bus.req_op    = 3'd1;
    lru_bus.req_addr  = 32'h0000;
    lru_bus.flush     = 1'b1;
    set_exp(1, 1, 0, 0);
    step();
    lru_bus.flush = 1'b0;
    run_load(3'd1, 32'h0004, 32'h01020304, 0, 32'h01020304, 1'b0, 5'd0, 1'b0);

    // reset in WAIT: back to idle, no response, late data ignored
    accept_and_issue(3'd1, 32'h0080);
    set_exp(1, 0, 0, 0);
    step();
    reset_n = 1'b0;
    set_exp(0, 1, 0, 0);
    @(negedge clk);
    chk("mid_rst_bus_addr", lru_bus.bus_addr, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    lru_bus.bus_rvalid = 1'b1;
    step();
    idle_inputs();
    step();

`ifdef LOAD_TIMEOUT_EN
    // no rvalid: code 7 after TO WAIT cycles, the late data is dropped
    accept_and_issue(3'd1, 32'h0000);
    for (int i = 0; i < TO; i++) begin
      set_exp(1, 0, 0, 0);
      step();
    end
    e_data = 32'h0;
    e_exc  = 1'b1;
    e_code = 5'd7;
    set_exp(0, 0, 0, 1);
    step();
    set_exp(0, 0, 0, 0);
    step();
    lru_bus.bus_rvalid = 1'b1;
    step();
    lru_bus.bus_rvalid = 1'b0;
    set_exp(0, 1, 0, 0);
    step();
`else
    // without the timeout option a long WAIT still completes normally
    run_load(3'd1, 32'h0200, 32'h55AA55AA, 24, 32'h55AA55AA, 1'b0, 5'd0, 1'b0);
`endif

    // randomized loads against the model
    for (int n = 0; n < 200; n++) begin
      op  = 3'($urandom_range(0, 7));
      a   = rand_addr();
      w   = 32'($urandom);
      if (op == 3'd0 || op > 3'd5) begin
        lru_bus.req_valid = 1'b1;
        lru_bus.req_op    = op;
        lru_bus.req_addr  = a;
        set_exp(0, 1, 0, 0);
        step();
        idle_inputs();
      end else begin
        bad = model_bad(op, a);
        run_load(op, a, w, $urandom_range(0, 6), bad ? 32'h0 : model_ext(op, a, w),
                 bad, bad ? 5'd4 : 5'd0, 1'($urandom_range(0, 1)));
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        lru_bus.bus_rvalid = 1'($urandom_range(0, 1));
        set_exp(0, 1, 0, 0);
        step();
        idle_inputs();
      end
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
